// File: rtl/clockctrl_pkg.sv
// Shared types and constants for the clockctrl strobe generator.
package clockctrl_pkg;

    // Default widths of the phase counters, burst/period counters and register words
    localparam int unsigned CntWidthDef   = 16;
    localparam int unsigned BurstWidthDef = 16;
    localparam int unsigned RegWidthDef   = 32;

    // CTRL register bit positions
    localparam int unsigned CtrlEnable   = 0;
    localparam int unsigned CtrlPolarity = 1;
    localparam int unsigned CtrlRestart  = 2;

    // STATUS register bit positions
    localparam int unsigned StatusRunning    = 0;
    localparam int unsigned StatusDone       = 1;
    localparam int unsigned StatusCfgPending = 2;
    localparam int unsigned StatusCountLsb   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StDone
    } gen_state_e;

endpackage

// File: rtl/clockctrl_phase_cnt.sv
// Loadable down-counter with zero flag, shared by the HIGH and LOW phases.
module clockctrl_phase_cnt #(
    parameter int unsigned C_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [C_WIDTH-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    localparam logic [C_WIDTH-1:0] One = {{(C_WIDTH-1){1'b0}}, 1'b1};

    logic [C_WIDTH-1:0] cnt_q;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - One;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clockctrl_gen_core.sv
// Programmable clock/strobe generator driven by the clockctrl register file.
module clockctrl_gen_core
    import clockctrl_pkg::*;
#(
    parameter int unsigned C_CNT_WIDTH   = CntWidthDef,
    parameter int unsigned C_BURST_WIDTH = BurstWidthDef,
    parameter int unsigned C_REG_WIDTH   = RegWidthDef
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    input  logic [C_REG_WIDTH-1:0] reg_ctrl,
    input  logic [C_REG_WIDTH-1:0] reg_high,
    input  logic [C_REG_WIDTH-1:0] reg_low,
    input  logic [C_REG_WIDTH-1:0] reg_burst,
    output logic                   gen_out,
    output logic                   gen_rise,
    output logic                   gen_fall,
    output logic [C_REG_WIDTH-1:0] status
);

    localparam logic [C_CNT_WIDTH-1:0]   CntOne   = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_BURST_WIDTH-1:0] BurstOne = {{(C_BURST_WIDTH-1){1'b0}}, 1'b1};

    gen_state_e               state_q, state_d;
    logic                     pol_q, pol_d;
    logic [C_BURST_WIDTH-1:0] count_q, count_d, count_inc;
    logic [C_CNT_WIDTH-1:0]   high_sh_q, high_sh_d, low_sh_q, low_sh_d;
    logic [C_BURST_WIDTH-1:0] burst_sh_q, burst_sh_d;
    logic                     pending_q, pending_d;
    logic                     restart_q;
    logic                     gen_out_q, gen_out_d, rise_q, rise_d, fall_q, fall_d;

    logic                     enable, restart_edge, start;
    logic [C_CNT_WIDTH-1:0]   high_len, low_len;
    logic [C_BURST_WIDTH-1:0] burst_len;
    logic                     cnt_load, cnt_dec, cnt_zero;
    logic [C_CNT_WIDTH-1:0]   cnt_val;
    logic                     unused_reg_bits;

    assign enable       = reg_ctrl[CtrlEnable];
    assign restart_edge = reg_ctrl[CtrlRestart] & ~restart_q;

    // A programmed length of zero behaves as one cycle
    assign high_len  = (reg_high[C_CNT_WIDTH-1:0] == '0) ? CntOne : reg_high[C_CNT_WIDTH-1:0];
    assign low_len   = (reg_low[C_CNT_WIDTH-1:0] == '0) ? CntOne : reg_low[C_CNT_WIDTH-1:0];
    assign burst_len = reg_burst[C_BURST_WIDTH-1:0];
    assign count_inc = (count_q == '1) ? count_q : count_q + BurstOne;

    assign unused_reg_bits = ^{reg_ctrl[C_REG_WIDTH-1:CtrlRestart+1],
                               reg_high[C_REG_WIDTH-1:C_CNT_WIDTH],
                               reg_low[C_REG_WIDTH-1:C_CNT_WIDTH],
                               reg_burst[C_REG_WIDTH-1:C_BURST_WIDTH]};

    clockctrl_phase_cnt #(
        .C_WIDTH (C_CNT_WIDTH)
    ) u_phase_cnt (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, shadow config and registered-output decode
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        high_sh_d  = high_sh_q;
        low_sh_d   = low_sh_q;
        burst_sh_d = burst_sh_q;
        start      = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = high_len - CntOne;

        if (restart_edge) begin
            // Restart beats everything, including a coincident period end
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        start   = 1'b1;
                        count_d = '0;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (cnt_zero) begin
                        state_d  = StLow;
                        cnt_load = 1'b1;
                        cnt_val  = low_sh_q - CntOne;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StLow: begin
                    if (cnt_zero) begin
                        count_d = count_inc;
                        if ((burst_sh_q != '0) && (count_inc == burst_sh_q)) begin
                            state_d = StDone;
                        end else if (!enable) begin
                            state_d = StIdle;
                        end else begin
                            start   = 1'b1;
                            state_d = StHigh;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StDone: begin
                    if (!enable) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Period start: capture new config and load the HIGH phase length
        if (start) begin
            high_sh_d  = high_len;
            low_sh_d   = low_len;
            burst_sh_d = burst_len;
            cnt_load   = 1'b1;
            cnt_val    = high_len - CntOne;
        end

        pol_d     = ((state_d == StIdle) || start) ? reg_ctrl[CtrlPolarity] : pol_q;
        pending_d = (state_d != StIdle) &&
                    ((high_len != high_sh_d) || (low_len != low_sh_d) ||
                     (burst_len != burst_sh_d));
        gen_out_d = pol_d ^ (state_d == StHigh);
        rise_d    = (state_d == StHigh) && (state_q != StHigh);
        fall_d    = (state_q == StHigh) && (state_d != StHigh);
    end

    // State, shadow config and output registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q    <= StIdle;
            pol_q      <= 1'b0;
            count_q    <= '0;
            high_sh_q  <= '0;
            low_sh_q   <= '0;
            burst_sh_q <= '0;
            pending_q  <= 1'b0;
            restart_q  <= 1'b0;
            gen_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pol_q      <= pol_d;
            count_q    <= count_d;
            high_sh_q  <= high_sh_d;
            low_sh_q   <= low_sh_d;
            burst_sh_q <= burst_sh_d;
            pending_q  <= pending_d;
            restart_q  <= reg_ctrl[CtrlRestart];
            gen_out_q  <= gen_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // Status word assembly from registered state
    always_comb begin
        status                                   = '0;
        status[StatusRunning]                    = (state_q == StHigh) || (state_q == StLow);
        status[StatusDone]                       = (state_q == StDone);
        status[StatusCfgPending]                 = pending_q;
        status[StatusCountLsb +: C_BURST_WIDTH]  = count_q;
    end

    assign gen_out  = gen_out_q;
    assign gen_rise = rise_q;
    assign gen_fall = fall_q;

endmodule

// File: tb/tb_clockctrl_gen_core.sv
// Scoreboard bench for clockctrl_gen_core: a cycle model predicts each output cycle.
module tb_clockctrl_gen_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg_ctrl, reg_high, reg_low, reg_burst;
    logic        gen_out, gen_rise, gen_fall;
    logic [31:0] status;

    clockctrl_gen_core dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .reg_ctrl        (reg_ctrl),
        .reg_high        (reg_high),
        .reg_low         (reg_low),
        .reg_burst       (reg_burst),
        .gen_out         (gen_out),
        .gen_rise        (gen_rise),
        .gen_fall        (gen_fall),
        .status          (status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        out;
        logic        rise;
        logic        fall;
        logic [31:0] status;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   cycle    = 0;

    // Reference model: phase timed by an up-counting elapsed-cycle count
    localparam logic [1:0] MIdle = 2'd0, MHigh = 2'd1, MLow = 2'd2, MDone = 2'd3;
    logic [1:0]  m_state;
    logic [15:0] m_elapsed, m_hi, m_lo, m_burst, m_count;
    logic        m_pol, m_rprev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = MIdle;
        m_elapsed = '0;
        m_hi      = '0;
        m_lo      = '0;
        m_burst   = '0;
        m_count   = '0;
        m_pol     = 1'b0;
        m_rprev   = 1'b0;
    endtask

    // Predict the outputs after the coming clock edge from the inputs now applied
    task automatic model_step();
        logic        en, rs, start, pend;
        logic [1:0]  nxt;
        logic [15:0] hl, ll, bl;
        exp_t        e;
        en      = reg_ctrl[0];
        rs      = reg_ctrl[2] & ~m_rprev;
        m_rprev = reg_ctrl[2];
        hl      = (reg_high[15:0] == 16'd0) ? 16'd1 : reg_high[15:0];
        ll      = (reg_low[15:0] == 16'd0) ? 16'd1 : reg_low[15:0];
        bl      = reg_burst[15:0];
        nxt     = m_state;
        start   = 1'b0;
        if (rs) begin
            nxt     = MIdle;
            m_count = '0;
        end else begin
            case (m_state)
                MIdle: if (en) begin
                    start   = 1'b1;
                    m_count = '0;
                    nxt     = MHigh;
                end
                MHigh: begin
                    m_elapsed = m_elapsed + 16'd1;
                    if (m_elapsed == m_hi) begin
                        nxt       = MLow;
                        m_elapsed = '0;
                    end
                end
                MLow: begin
                    m_elapsed = m_elapsed + 16'd1;
                    if (m_elapsed == m_lo) begin
                        if (m_count != 16'hffff) m_count = m_count + 16'd1;
                        if ((m_burst != 16'd0) && (m_count == m_burst)) nxt = MDone;
                        else if (!en) nxt = MIdle;
                        else begin
                            start = 1'b1;
                            nxt   = MHigh;
                        end
                    end
                end
                default: if (!en) nxt = MIdle;
            endcase
        end
        if (start) begin
            m_hi      = hl;
            m_lo      = ll;
            m_burst   = bl;
            m_elapsed = '0;
        end
        if ((nxt == MIdle) || start) m_pol = reg_ctrl[1];
        pend     = (nxt != MIdle) && ((hl != m_hi) || (ll != m_lo) || (bl != m_burst));
        e.out    = m_pol ^ (nxt == MHigh);
        e.rise   = (nxt == MHigh) && (m_state != MHigh);
        e.fall   = (m_state == MHigh) && (nxt != MHigh);
        e.status = {m_count, 13'd0, pend, (nxt == MDone), ((nxt == MHigh) || (nxt == MLow))};
        m_state  = nxt;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        e = sb_q.pop_front();
        check_val("gen_out", {31'd0, gen_out}, {31'd0, e.out});
        check_val("gen_rise", {31'd0, gen_rise}, {31'd0, e.rise});
        check_val("gen_fall", {31'd0, gen_fall}, {31'd0, e.fall});
        check_val("status", status, e.status);
        rise_cnt += int'(gen_rise);
        fall_cnt += int'(gen_fall);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_regs(input logic [31:0] c, input logic [31:0] h, input logic [31:0] l,
                            input logic [31:0] b);
        reg_ctrl  = c;
        reg_high  = h;
        reg_low   = l;
        reg_burst = b;
    endtask

    initial begin
        rst_n = 1'b0;
        set_regs(32'd0, 32'd0, 32'd0, 32'd0);
        model_reset();
        #12;
        check_val("reset_out", {31'd0, gen_out}, 32'd0);
        check_val("reset_rise", {31'd0, gen_rise}, 32'd0);
        check_val("reset_fall", {31'd0, gen_fall}, 32'd0);
        check_val("reset_status", status, 32'd0);
        #1 rst_n = 1'b1;
        run(2);

        // 2 high / 3 low free-running
        set_regs(32'd1, 32'd2, 32'd3, 32'd0);
        rise_cnt = 0;
        run(20);
        check_val("free_run_rises", rise_cnt, 32'd4);
        check_val("free_run_running", {31'd0, status[0]}, 32'd1);
        reg_ctrl = 32'd0;
        run(10);

        // Burst of 4 single-cycle periods
        set_regs(32'd1, 32'd1, 32'd1, 32'd4);
        rise_cnt = 0;
        fall_cnt = 0;
        run(12);
        check_val("burst_rises", rise_cnt, 32'd4);
        check_val("burst_falls", fall_cnt, 32'd4);
        check_val("burst_done_status", status, 32'h0004_0002);
        reg_ctrl = 32'd0;
        run(2);

        // Inverted polarity, 3 active / 2 inactive
        set_regs(32'd2, 32'd3, 32'd2, 32'd0);
        run(2);
        check_val("pol_idle_level", {31'd0, gen_out}, 32'd1);
        reg_ctrl = 32'd3;
        run(10);
        reg_ctrl = 32'd2;
        run(8);

        // Config change mid-high is deferred to the next period
        set_regs(32'd1, 32'd4, 32'd2, 32'd0);
        run(2);
        reg_high = 32'd8;
        step();
        check_val("cfg_pending_set", {31'd0, status[2]}, 32'd1);
        run(30);
        reg_ctrl = 32'd0;
        run(20);

        // Disable one cycle into a 10/10 period
        set_regs(32'd1, 32'd10, 32'd10, 32'd0);
        step();
        reg_ctrl = 32'd0;
        run(20);
        check_val("disable_status", status, 32'h0001_0000);
        check_val("disable_out", {31'd0, gen_out}, 32'd0);

        // Async reset mid-high
        set_regs(32'd1, 32'd5, 32'd5, 32'd0);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out", {31'd0, gen_out}, 32'd0);
        check_val("async_rst_status", status, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;

        // Restart edge mid-low of the second period
        run(17);
        check_val("pre_restart_count", {16'd0, status[31:16]}, 32'd1);
        reg_ctrl = 32'd5;
        step();
        check_val("restart_status", status, 32'd0);
        step();
        reg_ctrl = 32'd1;
        run(6);

        // Restart edge coinciding with a period end
        reg_ctrl = 32'd0;
        run(12);
        set_regs(32'd1, 32'd1, 32'd1, 32'd0);
        run(2);
        reg_ctrl = 32'd5;
        step();
        check_val("restart_wins_status", status, 32'd0);
        reg_ctrl = 32'd1;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
